axi_burst_ctrl: RTL

AXI_BURST_CTRL -- requirements
Module: axi_burst_ctrl

---
 rtl/axi_burst_ctrl_pkg.sv | 31 +++
 rtl/axi_burst_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// axi_burst_ctrl_pkg
// Shared cache package: burst controller state encoding, AXI burst-type and
// response constants, and a response-classification helper.
// -----------------------------------------------------------------------------
package axi_burst_ctrl_pkg;

    // Controller state encoding (kept as plain constants for legacy tools)
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_AR   = 3'd1;
    localparam state_t ST_R    = 3'd2;
    localparam state_t ST_AW   = 3'd3;
    localparam state_t ST_W    = 3'd4;
    localparam state_t ST_B    = 3'd5;

    // AXI burst type and response codes
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Anything other than OKAY is treated as an error, including EXOKAY,
    // because the controller never issues exclusive accesses.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi_burst_ctrl.sv
// -----------------------------------------------------------------------------
// axi_burst_ctrl
// Moves one cache block over AXI as a single INCR burst: refill (AR + R) or
// writeback (AW + W + B). The data path lives in a shift register beside this
// block; this controller only sequences it through load_o / shift_en_o.
//
// Ports
//   clk_i, arst_i             clock, asynchronous active-high reset
//   req_rd_i, req_wr_i        refill / writeback requests (level, IDLE only)
//   addr_i                    block-aligned address, latched on accept
//   busy_o, done_o, err_o     status; done_o is a one-cycle pulse, err_o
//                             qualifies it
//   load_o, shift_en_o        shift register parallel-load / shift enable
//   ax_len_o/size_o/burst_o   constant burst attributes
//   ar*/r*/aw*/w*/b*          AXI master channel handshakes
// -----------------------------------------------------------------------------
module axi_burst_ctrl
    import axi_burst_ctrl_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BLOCK_WIDTH    = 512,
    parameter int AXI_ADDR_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      req_rd_i,
    input  logic                      req_wr_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      load_o,
    output logic                      shift_en_o,
    output logic [7:0]                ax_len_o,
    output logic [2:0]                ax_size_o,
    output logic [1:0]                ax_burst_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    output logic [AXI_ADDR_WIDTH-1:0] araddr_o,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    input  logic                      rlast_i,
    input  logic [1:0]                rresp_i,
    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [AXI_ADDR_WIDTH-1:0] awaddr_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    output logic                      wlast_o,
    input  logic                      bvalid_i,
    output logic                      bready_o,
    input  logic [1:0]                bresp_i
);

    localparam int BEATS  = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SIZE_L = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [CNT_W-1:0]            cnt_r;
    logic                        err_r;
    logic                        done_r;
    logic [AXI_ADDR_WIDTH-1:0]   addr_r;

    logic                        idle_s;
    logic                        accept_s;
    logic                        last_s;
    logic                        ar_hs_s;
    logic                        r_hs_s;
    logic                        aw_hs_s;
    logic                        w_hs_s;
    logic                        b_hs_s;
    logic                        err_set_s;

    assign idle_s   = (state_r == ST_IDLE);
    assign accept_s = idle_s & (req_wr_i | req_rd_i);
    assign last_s   = (cnt_r == LAST_BEAT);

    assign ar_hs_s  = (state_r == ST_AR) & arready_i;
    assign r_hs_s   = (state_r == ST_R)  & rvalid_i;
    assign aw_hs_s  = (state_r == ST_AW) & awready_i;
    assign w_hs_s   = (state_r == ST_W)  & wready_i;
    assign b_hs_s   = (state_r == ST_B)  & bvalid_i;

    // A read beat is flagged when its response is bad or RLAST disagrees with
    // our own beat count; the count alone still decides completion.
    assign err_set_s = (r_hs_s & (resp_is_err(rresp_i) | (rlast_i != last_s)))
                     | (b_hs_s & resp_is_err(bresp_i));

    // Next-state selection; writeback has priority over refill in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_wr_i) begin
                    state_nxt_s = ST_AW;
                end else if (req_rd_i) begin
                    state_nxt_s = ST_AR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_AR: begin
                if (arready_i) begin
                    state_nxt_s = ST_R;
                end else begin
                    state_nxt_s = ST_AR;
                end
            end
            ST_R: begin
                if (r_hs_s && last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_R;
                end
            end
            ST_AW: begin
                if (awready_i) begin
                    state_nxt_s = ST_W;
                end else begin
                    state_nxt_s = ST_AW;
                end
            end
            ST_W: begin
                if (w_hs_s && last_s) begin
                    state_nxt_s = ST_B;
                end else begin
                    state_nxt_s = ST_W;
                end
            end
            ST_B: begin
                if (bvalid_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_B;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, beat counter, sticky error, latched address and done pulse
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            addr_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (r_hs_s & last_s) | b_hs_s;

            if (accept_s) begin
                addr_r <= addr_i;
            end else begin
                addr_r <= addr_r;
            end

            if (ar_hs_s || aw_hs_s) begin
                cnt_r <= '0;
            end else if (r_hs_s || w_hs_s) begin
                cnt_r <= last_s ? '0 : (cnt_r + CNT_W'(1));
            end else begin
                cnt_r <= cnt_r;
            end

            if (accept_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Channel controls decode straight from the state register, so every
    // valid/ready falls together with the asynchronous reset.
    assign busy_o     = ~idle_s;
    assign done_o     = done_r;
    assign err_o      = err_r & done_r;
    assign load_o     = idle_s & req_wr_i & ~arst_i;
    assign shift_en_o = r_hs_s | w_hs_s;

    assign arvalid_o  = (state_r == ST_AR);
    assign araddr_o   = addr_r;
    assign rready_o   = (state_r == ST_R);
    assign awvalid_o  = (state_r == ST_AW);
    assign awaddr_o   = addr_r;
    assign wvalid_o   = (state_r == ST_W);
    assign wlast_o    = (state_r == ST_W) & last_s;
    assign bready_o   = (state_r == ST_B);

    assign ax_len_o   = 8'(BEATS - 1);
    assign ax_size_o  = 3'(SIZE_L);
    assign ax_burst_o = AXI_BURST_INCR;

endmodule
